// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide add/subtract sequencer that drives one shared 4-bit adder,
// one nibble per clock, least significant nibble first.
//
// state | meaning
// IDLE  | waiting for start; adder inputs held at zero
// RUN   | one nibble per cycle through the shared adder, carry chained
// DONE  | result registered, one-cycle done pulse
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic           carry_reg;
    logic [W-1:0]   a_lat;
    logic [W-1:0]   b_lat;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_next;
    logic [W-1:0]   a_shift;
    logic [W-1:0]   b_shift;

    // Current nibble is shifted down to bit 0 so the adder taps a fixed slice.
    always_comb begin
        a_shift  = a_lat >> {idx, 2'b00};
        b_shift  = b_lat >> {idx, 2'b00};
        acc_next = acc;
        acc_next[{idx, 2'b00} +: 4] = add_sum;
        add_a    = 4'd0;
        add_b    = 4'd0;
        add_cin  = 1'b0;
        if (state == RUN) begin
            add_a   = a_shift[3:0];
            add_b   = b_shift[3:0];
            add_cin = carry_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_lat     <= '0;
            b_lat     <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtract as a + ~b + 1; the final carry then means "no borrow".
                        a_lat     <= a;
                        b_lat     <= op_sub ? ~b : b;
                        carry_reg <= op_sub ? 1'b1 : cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    acc       <= acc_next;
                    carry_reg <= add_cout;
                    if (idx == LAST) begin
                        sum   <= acc_next;
                        cout  <= add_cout;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
